// File: rtl/data_mem_responder_pkg.sv
// Shared constants and byte-lane helpers for the data memory responder.
package dmem_pkg;

    localparam logic [7:0] CONSOLE_TX = 8'h00;
    localparam logic [7:0] STATUS     = 8'h04;
    localparam logic [7:0] CYCLE_LO   = 8'h08;
    localparam logic [7:0] CYCLE_HI   = 8'h0C;
    localparam logic [7:0] EXIT       = 8'h10;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    function automatic logic [3:0] lane_enable(input logic [3:0] mask, input logic [1:0] off);
        return mask << off;
    endfunction

    function automatic logic [31:0] lane_data(input logic [31:0] data, input logic [1:0] off);
        return data << {off, 3'b000};
    endfunction

    function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] off);
        return word >> {off, 3'b000};
    endfunction

    function automatic logic misaligned(input logic [3:0] mask, input logic [1:0] off);
        return (mask == MASK_H && off[0]) || (mask == MASK_W && off != 2'b00);
    endfunction

endpackage

// File: rtl/data_mem_responder_console_fifo.sv
// Synchronous FIFO buffering console bytes; head reads 0 while empty.
module console_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst && do_push)
            slots[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-port responder: lane-aligned word RAM plus console/status/cycle/exit MMIO.
// Optional 64-bit cycle counter enabled by DMEM_CYCLE_COUNTER_EN.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS   = 4096,
    parameter logic [31:0] MMIO_BASE     = 32'h1000_0000,
    parameter int unsigned CONSOLE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_enable,
    input  logic [3:0]  write_mask,
    output logic [31:0] read_data,
    output logic [7:0]  console_data,
    output logic        console_valid,
    input  logic        console_ready,
    output logic        halt,
    output logic [31:0] halt_code,
    output logic        err
);
    localparam int unsigned AW = $clog2(DEPTH_WORDS);
    localparam int unsigned CW = $clog2(CONSOLE_DEPTH) + 1;

    logic [31:0]   mem [DEPTH_WORDS];
    logic [AW-1:0] idx;
    logic [1:0]    off;
    logic [7:0]    mmio_off;
    logic          is_mmio;
    logic          bad_align;
    logic          ram_we;
    logic [3:0]    lanes;
    logic [31:0]   ldata;
    logic          unused_bits;

    assign off         = address[1:0];
    assign idx         = address[2 +: AW];
    assign mmio_off    = address[7:0];
    assign is_mmio     = (address[31:28] == MMIO_BASE[31:28]);
    assign bad_align   = misaligned(write_mask, off);
    assign ram_we      = write_enable && !rst && !is_mmio && !bad_align;
    assign lanes       = lane_enable(write_mask, off);
    assign ldata       = lane_data(write_data, off);
    assign unused_bits = ^address;

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int unsigned b = 0; b < 4; b++)
                if (lanes[b])
                    mem[idx][8*b +: 8] <= ldata[8*b +: 8];
        end
    end

    logic          tx_store;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;
    logic [CW-1:0] fifo_count;
    logic [31:0]   status;

    assign tx_store      = write_enable && is_mmio && (mmio_off == CONSOLE_TX) && !bad_align;
    assign console_valid = !fifo_empty;
    assign fifo_pop      = console_valid && console_ready;
    assign overflow      = tx_store && fifo_full && !fifo_pop;
    assign status        = {16'b0, 8'(fifo_count), 7'b0, fifo_full};

    console_fifo #(
        .DEPTH (CONSOLE_DEPTH),
        .WIDTH (8)
    ) u_console_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_store),
        .push_data (write_data[7:0]),
        .pop       (fifo_pop),
        .head      (console_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    logic [63:0] cycles;
`ifdef DMEM_CYCLE_COUNTER_EN
    always_ff @(posedge clk) begin
        if (rst)
            cycles <= '0;
        else
            cycles <= cycles + 64'd1;
    end
`else
    assign cycles = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            halt      <= 1'b0;
            halt_code <= '0;
            err       <= 1'b0;
        end else begin
            if ((write_enable && bad_align) || overflow)
                err <= 1'b1;
            // Only the first exit store is captured; later ones wait for reset.
            if (write_enable && is_mmio && (mmio_off == EXIT) && !bad_align && !halt) begin
                halt      <= 1'b1;
                halt_code <= write_data;
            end
        end
    end

    always_comb begin
        read_data = '0;
        if (is_mmio) begin
            case (mmio_off)
                STATUS:   read_data = status;
                CYCLE_LO: read_data = cycles[31:0];
                CYCLE_HI: read_data = cycles[63:32];
                default:  read_data = '0;
            endcase
        end else begin
            read_data = lane_extract(mem[idx], off);
        end
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the pipelined RV32 core's data port: it answers the core's address/write_data/write_enable/write_mask/read_data interface with a word-organised RAM plus a small MMIO region. It performs byte-lane alignment, because the core issues unshifted lane masks and data and sign-extends loads from bits [7:0]/[15:0]. It also provides a console byte FIFO with a valid/ready drain port, a halt/exit register, and a free-running cycle counter. It sits beside the core in the SoC top and the simulation harness.

## Interface
- DEPTH_WORDS, 4096: RAM size in 32-bit words; must be a power of two.
- MMIO_BASE, 32'h1000_0000: base of the MMIO region. Decode compares address[31:28] only.
- CONSOLE_DEPTH, 4: console FIFO entries; must be a power of two and at least 2.

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- address  in  32  byte address from the core's M stage
- write_data  in  32  store data, unshifted (byte/half in low bits)
- write_enable  in  1  store strobe
- write_mask  in  4  unshifted size mask: 0001 byte, 0011 half, 1111 word
- read_data  out  32  load data, right-justified to the byte offset; combinational
- console_data  out  8  FIFO head byte
- console_valid  out  1  FIFO not empty
- console_ready  in  1  consumer accepts head this cycle
- halt  out  1  exit register written (sticky)
- halt_code  out  32  value written to exit register
- err  out  1  sticky: misaligned store or console overflow

## Operation
- Decode:
  - MMIO when address[31:28] == MMIO_BASE[31:28].
  - Otherwise RAM word index = address[2 +: log2(DEPTH_WORDS)]. Upper bits are ignored, so the RAM aliases.
- RAM read: read_data = mem[idx] >> (8*address[1:0]), zero-filled. The core performs sign/zero extension.
- RAM write at posedge when write_enable:
  - Lane enable = write_mask << address[1:0], truncated to 4 bits.
  - Lane data = write_data << (8*address[1:0]).
  - Each enabled byte is written.
- Misaligned store (half with address[0]=1, word with address[1:0]≠0): the write is dropped and err is set. Misaligned loads cannot be detected because the port has no load strobe; they return the shifted word.
- RAM contents are not cleared by rst.
- MMIO offsets (address[7:0]):
  - 0x00 console TX. A store pushes write_data[7:0]. Reads return 0.
  - 0x04 status. Read = {16'b0, 8'(count), 7'b0, full}. Writes are ignored.
  - 0x08 / 0x0C cycle counter low / high (read-only).
  - 0x10 exit. The first store sets halt=1 and halt_code=write_data. Later stores are ignored until rst.
  - Other offsets read 0; writes to them are ignored.
- Console FIFO:
  - Push when a store hits 0x00 and (not full OR pop this cycle).
  - Pop when console_valid && console_ready.
  - A push while full with no pop drops the byte and sets err.
  - Simultaneous push and pop leaves count unchanged, with the head advancing.
  - Pointers wrap modulo CONSOLE_DEPTH. count is 0..CONSOLE_DEPTH.

## Timing
- Reads: zero latency, combinational from address. The core samples read_data on the edge that closes its M stage.
- Write to a RAM/MMIO location at edge N is visible to reads from cycle N+1. A same-cycle read of the location being written returns the old value.
- Console: a push at edge N raises console_valid after N. A byte pushed into an empty FIFO can be popped at edge N+1 at the earliest.
- Reset values: read_data follows the address combinationally; console_valid=0; console_data=0; halt=0; halt_code=0; err=0; FIFO count=0; counter=0.
- rst asserted mid-operation empties the FIFO, clears halt/err/counter, and discards any same-cycle store to MMIO. RAM stores in a reset cycle are also discarded.

## Configuration
- DMEM_CYCLE_COUNTER_EN:
  - Defined: a 64-bit counter increments every cycle that rst is low and wraps to 0 after all-ones. Offsets 0x08/0x0C return bits [31:0]/[63:32].
  - Undefined: the counter is absent and 0x08/0x0C read 0.

## Structure
- Package dmem_pkg:
  - MMIO offset constants (CONSOLE_TX=8'h00, STATUS=8'h04, CYCLE_LO=8'h08, CYCLE_HI=8'h0C, EXIT=8'h10).
  - Size-mask constants (MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111).
  - Lane align/extract functions.
- Sub-module console_fifo: parameterised synchronous FIFO with push/pop, full/empty and count. Its full and count drive the status word.

## Test plan
- sb 0xA5 to 0x0000_0102, then load 0x0000_0102 -> read_data[7:0]=0xA5. Word read at 0x100 shows 0x00A5_0000 in the lanes over prior zeros.
- sw 0x1122_3344 to 0x200, then sh 0xBEEF to 0x202 -> word at 0x200 = 0xBEEF_3344. Load at 0x203 -> read_data = 0x0000_00BE.
- sh to 0x201 -> RAM unchanged and err=1 the next cycle. err stays 1 until rst.
- With console_ready=0, store 5 bytes 'a'..'e' to 0x1000_0000 (CONSOLE_DEPTH=4):
  - status after the 4th store reads 0x0000_0401, and err=1 after the 5th.
  - Raising console_ready then yields 'a','b','c','d' on consecutive cycles, after which console_valid=0.
- Store 0x0000_002A to 0x1000_0010, then 0x1 -> halt=1 and halt_code=0x2A. A rst mid-run clears halt, err and the FIFO.
- With DMEM_CYCLE_COUNTER_EN, release rst and wait 10 cycles -> 0x1000_0008 reads 10 (±0 by edge), 0x1000_000C reads 0. Without the macro both read 0.
